// File: rtl/stream_arb_2_to_1_pkg.sv
// Shared definitions for the two-input round-robin stream arbiter.
// Holds the default data width and the mux-select decision function.
package stream_arb_2_to_1_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  // Select for the datapath mux: a lone requester wins outright,
  // otherwise (both or neither requesting) the select follows prio.
  function automatic logic pick_sel(
    input logic v0,
    input logic v1,
    input logic prio
  );
    logic sel;
    sel = prio;
    unique case (1'b1)
      (v0 && !v1): sel = 1'b0;
      (v1 && !v0): sel = 1'b1;
      default:     sel = prio;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mux_2_to_1.sv
// Plain 2:1 word multiplexer (datapath of the stream arbiter).
// Ports: i_d0/i_d1 data in, i_s_l select (0 = d0, 1 = d1), o_y out.
module mux_2_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic             i_s_l,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_s_l ? i_d1 : i_d0;

endmodule

// File: rtl/stream_arb_2_to_1.sv
// Two-input round-robin valid/ready arbiter with a one-deep output
// register. Ports: clk, rst_n (sync, active low), in0_*/in1_* producer
// channels, s_l mux select, out_* consumer channel.
module stream_arb_2_to_1
  import stream_arb_2_to_1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             s_l,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             r_prio;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic             w_load_en;
  logic             w_sel;
  logic             w_rdy0;
  logic             w_rdy1;
  logic             w_xfer;
  logic [WIDTH-1:0] w_mux_y;

  // Output stage can accept when empty or draining this cycle.
  assign w_load_en = !r_out_valid || out_ready;
  assign w_sel     = pick_sel(in0_valid, in1_valid, r_prio);

  // A grant to K exists only when K is valid and the select is K.
  assign w_rdy0 = w_load_en && in0_valid && !w_sel;
  assign w_rdy1 = w_load_en && in1_valid && w_sel;
  assign w_xfer = w_rdy0 || w_rdy1;

  mux_2_to_1 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .i_d0 (in0_data),
    .i_d1 (in1_data),
    .i_s_l(w_sel),
    .o_y  (w_mux_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_mux_y;
      r_out_valid <= 1'b1;
      // Favour the channel that did not just win.
      r_prio      <= ~w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in0_ready = w_rdy0;
  assign in1_ready = w_rdy1;
  assign s_l       = w_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_stream_arb_2_to_1.sv
// Self-checking bench for stream_arb_2_to_1: directed scenarios plus
// randomized traffic against a behavioural arbitration model.
module tb_stream_arb_2_to_1;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in0_valid;
  logic [W-1:0] in0_data;
  logic         in0_ready;
  logic         in1_valid;
  logic [W-1:0] in1_data;
  logic         in1_ready;
  logic         s_l;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  int checks;
  int errors;

  stream_arb_2_to_1 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_valid(in0_valid),
    .in0_data (in0_data),
    .in0_ready(in0_ready),
    .in1_valid(in1_valid),
    .in1_data (in1_data),
    .in1_ready(in1_ready),
    .s_l      (s_l),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 32'h1234_5678;
    in1_data  = 32'h8765_4321;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", out_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_l !== 1'b0 || in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant got s_l=%b r0=%b r1=%b exp 0 1 0",
               s_l, in0_ready, in1_ready);
    end
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      in0_valid = 1'b1;
      in0_data  = W'(i);
      #1;
      checks++;
      if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_ready%0d got r0=%b r1=%b exp 1 0",
                 i, in0_ready, in1_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i)) begin
        errors++;
        $display("FAIL single_out%0d got v=%b d=%h exp 1 %h",
                 i, out_valid, out_data, W'(i));
      end
    end
    in0_valid = 1'b0;
  endtask

  task automatic test_alternation();
    logic [W-1:0] exp;
    do_reset();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in0_data = 32'hAAAA_0000 + W'((k + 1) / 2);
      in1_data = 32'h5555_0000 + W'(k / 2);
      #1;
      checks++;
      if (s_l !== 1'(k % 2)) begin
        errors++;
        $display("FAIL alt_sel%0d got %b exp %0d", k, s_l, k % 2);
      end
      exp = (k % 2 == 0) ? 32'hAAAA_0000 + W'(k / 2)
                         : 32'h5555_0000 + W'(k / 2);
      tick();
      checks++;
      if (out_data !== exp) begin
        errors++;
        $display("FAIL alt_out%0d got %h exp %h", k, out_data, exp);
      end
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in0_valid = 1'b1;
    in0_data  = 32'h0000_0002;
    tick();
    in1_valid = 1'b1;
    in0_data  = 32'h0000_0010;
    in1_data  = 32'h0000_0011;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready%0d got r0=%b r1=%b exp 0 0",
                 c, in0_ready, in1_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_0002) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h exp 1 2",
                 c, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got r0=%b r1=%b exp 0 1",
               in0_ready, in1_ready);
    end
    tick();
    in1_valid = 1'b0;
    checks++;
    if (out_data !== 32'h0000_0011) begin
      errors++;
      $display("FAIL bp_load got %h exp 11", out_data);
    end
    #1;
    checks++;
    if (in1_ready !== 1'b0 || in0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pulse got r0=%b r1=%b exp 1 0",
               in0_ready, in1_ready);
    end
    in0_valid = 1'b0;
  endtask

  task automatic test_drain();
    do_reset();
    in0_valid = 1'b1;
    in0_data  = 32'h0000_0077;
    tick();
    in0_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77) begin
      errors++;
      $display("FAIL drain_load got v=%b d=%h exp 1 77", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h77) begin
      errors++;
      $display("FAIL drain_empty got v=%b d=%h exp 0 77", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in0_valid = 1'b1;
    in0_data  = 32'h0000_0099;
    tick();
    in0_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_held got %b exp 1", out_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL rmid_clear got v=%b d=%h exp 0 0", out_valid, out_data);
    end
    checks++;
    if (s_l !== 1'b0) begin
      errors++;
      $display("FAIL rmid_prio got %b exp 0", s_l);
    end
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    in0_data  = 32'h0000_00A0;
    in1_data  = 32'h0000_00A1;
    #1;
    checks++;
    if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_grant got r0=%b r1=%b exp 1 0", in0_ready, in1_ready);
    end
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    checks++;
    if (out_data !== 32'h0000_00A0) begin
      errors++;
      $display("FAIL rmid_next got %h exp a0", out_data);
    end
  endtask

  task automatic test_random();
    logic         m_prio;
    logic         m_ov;
    logic [W-1:0] m_od;
    logic         acc0;
    logic         acc1;
    logic         e_sel;
    int           win;
    do_reset();
    m_prio = 1'b0;
    m_ov   = 1'b0;
    m_od   = '0;
    acc0   = 1'b1;
    acc1   = 1'b1;
    for (int c = 0; c < 400; c++) begin
      // Producers keep an un-accepted word steady.
      if (acc0 || !in0_valid) begin
        in0_valid = 1'($urandom_range(0, 1));
        in0_data  = $urandom;
      end
      if (acc1 || !in1_valid) begin
        in1_valid = 1'($urandom_range(0, 1));
        in1_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = -1;
      if (!m_ov || out_ready) begin
        if (in0_valid && (!in1_valid || m_prio == 1'b0)) win = 0;
        else if (in1_valid) win = 1;
      end
      e_sel = (in0_valid != in1_valid) ? in1_valid : m_prio;
      checks++;
      if (in0_ready !== (win == 0) || in1_ready !== (win == 1)) begin
        errors++;
        $display("FAIL rnd_ready c%0d got r0=%b r1=%b exp win=%0d",
                 c, in0_ready, in1_ready, win);
      end
      checks++;
      if (s_l !== e_sel) begin
        errors++;
        $display("FAIL rnd_sel c%0d got %b exp %b", c, s_l, e_sel);
      end
      checks++;
      if (out_valid !== m_ov || out_data !== m_od) begin
        errors++;
        $display("FAIL rnd_out c%0d got v=%b d=%h exp %b %h",
                 c, out_valid, out_data, m_ov, m_od);
      end
      if (win == 0) begin
        m_od = in0_data; m_ov = 1'b1; m_prio = 1'b1;
      end else if (win == 1) begin
        m_od = in1_data; m_ov = 1'b1; m_prio = 1'b0;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      acc0 = (win == 0);
      acc1 = (win == 1);
      tick();
    end
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_data  = '0;
    in1_data  = '0;
    out_ready = 1'b0;
    tick();
    test_reset();
    test_single();
    test_alternation();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
